lsq_dcache_port: RTL and testbench
==================================

Name: lsq_dcache_port

Overview:
- Memory-side consumer of the load/store queue head entry.
- Issues the head op to the data cache port and waits for the response.
- On response, pulses the dequeue strobe back to the queue. Loads produce an aligned, sign/zero-extended writeback for the CDB/regfile; stores produce a completion pulse to the ROB.
- Handles ROB flush with an in-flight request by draining the orphan response.

Parameters:
ROB_IDX_W, 5, width of ROB index (BITS_ROB_DEPTH+1)
PD_W, 6, physical destination register index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
head_valid  in  1  queue head entry valid
head_addr_valid  in  1  head address/data computed
head_is_store  in  1  1=store, 0=load
head_addr  in  32  byte address
head_wdata  in  32  store data, already lane-shifted
head_wmask  in  4  store byte mask
head_rmask  in  4  load byte mask
head_funct3  in  3  RV32I load/store funct3
head_rob_idx  in  ROB_IDX_W  ROB index of head op
head_pd  in  PD_W  load destination physical reg
rob_head_idx  in  ROB_IDX_W  current ROB head index
flush  in  1  ROB flush
dequeue  out  1  pop queue head (to LSQ dequeue_flag)
dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
dmem_rmask  out  4  read mask, nonzero only in request cycle
dmem_wmask  out  4  write mask, nonzero only in request cycle
dmem_wdata  out  32  write data
dmem_rdata  in  32  read data
dmem_resp  in  1  cache response
wb_valid  out  1  load result valid
wb_pd  out  PD_W  load destination
wb_rob_idx  out  ROB_IDX_W  load ROB index
wb_data  out  32  extended load data
store_done  out  1  store completed pulse
store_rob_idx  out  ROB_IDX_W  ROB index of completed store

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs and latched op fields 0.
- FSM states: IDLE, WAIT, DRAIN.
- IDLE issue condition: head_valid & head_addr_valid & !flush & (load | (store & head_rob_idx==rob_head_idx)). Stores issue only at ROB head; loads issue speculatively.
- IDLE issue action:
  - Drive dmem_* combinationally for exactly that cycle (masks nonzero, address word-aligned).
  - Latch addr[1:0], funct3, is_store, rob_idx, pd.
  - Next state WAIT.
- IDLE, no issue: all dmem masks 0.
- WAIT, dmem_resp=1, flush=0: dequeue=1 combinationally in the same cycle; next state IDLE. Next cycle, exactly one of:
  - load: wb_valid=1 with wb_pd, wb_rob_idx, wb_data;
  - store: store_done=1 with store_rob_idx.
  - Each is a one-cycle registered pulse.
- Back-to-back: a new issue is allowed in the IDLE cycle after the response, giving a minimum of 2 cycles per op plus cache latency.
- WAIT, flush=1, dmem_resp=0: next state DRAIN; dequeue=0.
- WAIT, flush=1 and dmem_resp=1 in the same cycle: discard the response; dequeue=0, no wb_valid/store_done; next state IDLE.
- DRAIN: dmem masks 0; on dmem_resp go to IDLE with no dequeue, wb_valid or store_done. Issue is blocked until IDLE.
- Flush in IDLE: no issue that cycle; any wb_valid/store_done pulse already registered for that cycle still appears.
- Load extraction, byte offset o=addr[1:0]:
  - 000 LB: sign-extend byte o.
  - 100 LBU: zero-extend byte o.
  - 001 LH: sign-extend half o[1].
  - 101 LHU: zero-extend half o[1].
  - 010 LW: full word.
  - Other funct3: wb_data=0.
- Alignment is guaranteed upstream; misaligned offsets are not checked.
- dmem_resp while in IDLE is ignored.
- Reset asserted mid-WAIT returns the block to IDLE immediately with no pulses.

Test Plan:
- LB at addr 0x1003, rdata 0x80AA_BBCC, resp after 3 cycles -> dmem_addr=0x1000, rmask 1000 for one cycle; dequeue on resp cycle; next cycle wb_valid=1, wb_data=0xFFFF_FF80.
- LHU at addr 0x2002, rdata 0x8001_1234 -> wb_data=0x0000_8001; LW at 0x2000 -> wb_data=0x8001_1234.
- Store with head_rob_idx=5, rob_head_idx=3 -> no request; set rob_head_idx=5 -> wmask issued one cycle; on resp, dequeue=1, then store_done=1 with store_rob_idx=5, no wb_valid.
- Load issued, flush 1 cycle later, resp 4 cycles later -> DRAIN; dequeue, wb_valid and store_done stay 0; next valid head issues the cycle after the response.
- flush and dmem_resp in the same WAIT cycle -> dequeue=0, no wb; state IDLE next cycle.
- rst_n pulsed low mid-WAIT -> all outputs 0 asynchronously; a later stray dmem_resp produces no dequeue.

Source files
------------

// File: rtl/lsq_dcache_port_if.sv
// Signal bundle between the LSQ head, the ROB, the data cache port and the writeback paths.
// The master modport is the dcache-port block; the slave modport is its environment.
interface lsq_dcache_port_if #(
    parameter int ROB_IDX_W = 5,
    parameter int PD_W      = 6
);
    logic                 head_valid;
    logic                 head_addr_valid;
    logic                 head_is_store;
    logic [31:0]          head_addr;
    logic [31:0]          head_wdata;
    logic [3:0]           head_wmask;
    logic [3:0]           head_rmask;
    logic [2:0]           head_funct3;
    logic [ROB_IDX_W-1:0] head_rob_idx;
    logic [PD_W-1:0]      head_pd;
    logic [ROB_IDX_W-1:0] rob_head_idx;
    logic                 flush;
    logic                 dequeue;
    logic [31:0]          dmem_addr;
    logic [3:0]           dmem_rmask;
    logic [3:0]           dmem_wmask;
    logic [31:0]          dmem_wdata;
    logic [31:0]          dmem_rdata;
    logic                 dmem_resp;
    logic                 wb_valid;
    logic [PD_W-1:0]      wb_pd;
    logic [ROB_IDX_W-1:0] wb_rob_idx;
    logic [31:0]          wb_data;
    logic                 store_done;
    logic [ROB_IDX_W-1:0] store_rob_idx;

    modport master (
        input  head_valid, head_addr_valid, head_is_store, head_addr, head_wdata,
               head_wmask, head_rmask, head_funct3, head_rob_idx, head_pd,
               rob_head_idx, flush, dmem_rdata, dmem_resp,
        output dequeue, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
               wb_valid, wb_pd, wb_rob_idx, wb_data, store_done, store_rob_idx
    );

    modport slave (
        output head_valid, head_addr_valid, head_is_store, head_addr, head_wdata,
               head_wmask, head_rmask, head_funct3, head_rob_idx, head_pd,
               rob_head_idx, flush, dmem_rdata, dmem_resp,
        input  dequeue, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
               wb_valid, wb_pd, wb_rob_idx, wb_data, store_done, store_rob_idx
    );
endinterface

// File: rtl/lsq_dcache_port.sv
// Issues the LSQ head op to the data cache, pops the queue on response and produces
// the load writeback or store completion pulse; drains orphan responses after a flush.
//   state | meaning
//   IDLE  | no request outstanding; head may issue this cycle
//   WAIT  | request issued, waiting for dmem_resp
//   DRAIN | flushed while outstanding; swallow the response
module lsq_dcache_port #(
    parameter int ROB_IDX_W = 5,
    parameter int PD_W      = 6
) (
    input logic                 clk,
    input logic                 rst_n,
    lsq_dcache_port_if.master   port
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           off_q, off_d;
    logic [2:0]           funct3_q, funct3_d;
    logic                 is_store_q, is_store_d;
    logic [ROB_IDX_W-1:0] rob_idx_q, rob_idx_d;
    logic [PD_W-1:0]      pd_q, pd_d;

    logic                 wb_valid_q, wb_valid_d;
    logic [PD_W-1:0]      wb_pd_q, wb_pd_d;
    logic [ROB_IDX_W-1:0] wb_rob_idx_q, wb_rob_idx_d;
    logic [31:0]          wb_data_q, wb_data_d;
    logic                 store_done_q, store_done_d;
    logic [ROB_IDX_W-1:0] store_rob_idx_q, store_rob_idx_d;

    logic                 issue_ok;
    logic                 dequeue;
    logic [31:0]          dmem_addr;
    logic [3:0]           dmem_rmask;
    logic [3:0]           dmem_wmask;
    logic [31:0]          dmem_wdata;

    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            3'b010:  r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // rst_n gates issue so the request lines stay quiet while reset is held
    assign issue_ok = rst_n & port.head_valid & port.head_addr_valid & ~port.flush &
                      (~port.head_is_store | (port.head_rob_idx == port.rob_head_idx));

    always_comb begin
        state_d         = state_q;
        off_d           = off_q;
        funct3_d        = funct3_q;
        is_store_d      = is_store_q;
        rob_idx_d       = rob_idx_q;
        pd_d            = pd_q;
        wb_valid_d      = 1'b0;
        wb_pd_d         = wb_pd_q;
        wb_rob_idx_d    = wb_rob_idx_q;
        wb_data_d       = wb_data_q;
        store_done_d    = 1'b0;
        store_rob_idx_d = store_rob_idx_q;
        dequeue         = 1'b0;
        dmem_addr       = 32'd0;
        dmem_rmask      = 4'd0;
        dmem_wmask      = 4'd0;
        dmem_wdata      = 32'd0;

        case (state_q)
            IDLE: begin
                if (issue_ok) begin
                    dmem_addr = {port.head_addr[31:2], 2'b00};
                    if (port.head_is_store) begin
                        dmem_wmask = port.head_wmask;
                        dmem_wdata = port.head_wdata;
                    end else begin
                        dmem_rmask = port.head_rmask;
                    end
                    off_d      = port.head_addr[1:0];
                    funct3_d   = port.head_funct3;
                    is_store_d = port.head_is_store;
                    rob_idx_d  = port.head_rob_idx;
                    pd_d       = port.head_pd;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (port.dmem_resp) begin
                    state_d = IDLE;
                    // a response racing a flush belongs to a squashed op
                    if (!port.flush) begin
                        dequeue = 1'b1;
                        if (is_store_q) begin
                            store_done_d    = 1'b1;
                            store_rob_idx_d = rob_idx_q;
                        end else begin
                            wb_valid_d   = 1'b1;
                            wb_pd_d      = pd_q;
                            wb_rob_idx_d = rob_idx_q;
                            wb_data_d    = load_ext(port.dmem_rdata, off_q, funct3_q);
                        end
                    end
                end else if (port.flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (port.dmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            off_q           <= 2'd0;
            funct3_q        <= 3'd0;
            is_store_q      <= 1'b0;
            rob_idx_q       <= '0;
            pd_q            <= '0;
            wb_valid_q      <= 1'b0;
            wb_pd_q         <= '0;
            wb_rob_idx_q    <= '0;
            wb_data_q       <= 32'd0;
            store_done_q    <= 1'b0;
            store_rob_idx_q <= '0;
        end else begin
            state_q         <= state_d;
            off_q           <= off_d;
            funct3_q        <= funct3_d;
            is_store_q      <= is_store_d;
            rob_idx_q       <= rob_idx_d;
            pd_q            <= pd_d;
            wb_valid_q      <= wb_valid_d;
            wb_pd_q         <= wb_pd_d;
            wb_rob_idx_q    <= wb_rob_idx_d;
            wb_data_q       <= wb_data_d;
            store_done_q    <= store_done_d;
            store_rob_idx_q <= store_rob_idx_d;
        end
    end

    assign port.dequeue       = dequeue;
    assign port.dmem_addr     = dmem_addr;
    assign port.dmem_rmask    = dmem_rmask;
    assign port.dmem_wmask    = dmem_wmask;
    assign port.dmem_wdata    = dmem_wdata;
    assign port.wb_valid      = wb_valid_q;
    assign port.wb_pd         = wb_pd_q;
    assign port.wb_rob_idx    = wb_rob_idx_q;
    assign port.wb_data       = wb_data_q;
    assign port.store_done    = store_done_q;
    assign port.store_rob_idx = store_rob_idx_q;

endmodule

// File: tb/tb_lsq_dcache_port.sv
// Directed bench for lsq_dcache_port: loads of every width, gated stores, flush/drain
// paths and reset during an outstanding request. Inputs change after posedge, outputs are read at negedge.
module tb_lsq_dcache_port;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    lsq_dcache_port_if #(.ROB_IDX_W(5), .PD_W(6)) bus ();

    lsq_dcache_port #(.ROB_IDX_W(5), .PD_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .port  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_load(input logic [31:0] addr, input logic [2:0] f3, input logic [3:0] rmask);
        bus.head_valid      = 1'b1;
        bus.head_addr_valid = 1'b1;
        bus.head_is_store   = 1'b0;
        bus.head_addr       = addr;
        bus.head_funct3     = f3;
        bus.head_rmask      = rmask;
        bus.head_wmask      = 4'd0;
        bus.head_wdata      = 32'd0;
        bus.head_pd         = 6'd9;
        bus.head_rob_idx    = 5'd2;
    endtask

    // Issue one load, respond after lat WAIT cycles, check the writeback pulse.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [3:0] rmask, input logic [31:0] rdata, input int lat,
                           input logic [31:0] exp_data);
        set_load(addr, f3, rmask);
        smp();
        check({tag, "_addr"}, bus.dmem_addr, {addr[31:2], 2'b00});
        check({tag, "_rmask"}, {28'd0, bus.dmem_rmask}, {28'd0, rmask});
        check({tag, "_wmask"}, {28'd0, bus.dmem_wmask}, 32'd0);
        tick();
        bus.head_valid = 1'b0;
        for (int i = 1; i < lat; i++) begin
            smp();
            check({tag, "_wait_rmask"}, {28'd0, bus.dmem_rmask}, 32'd0);
            check({tag, "_wait_deq"}, {31'd0, bus.dequeue}, 32'd0);
            tick();
        end
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = rdata;
        smp();
        check({tag, "_deq"}, {31'd0, bus.dequeue}, 32'd1);
        check({tag, "_early_wb"}, {31'd0, bus.wb_valid}, 32'd0);
        tick();
        bus.dmem_resp = 1'b0;
        smp();
        check({tag, "_wb_valid"}, {31'd0, bus.wb_valid}, 32'd1);
        check({tag, "_wb_data"}, bus.wb_data, exp_data);
        check({tag, "_wb_pd"}, {26'd0, bus.wb_pd}, 32'd9);
        check({tag, "_wb_rob"}, {27'd0, bus.wb_rob_idx}, 32'd2);
        check({tag, "_sdone"}, {31'd0, bus.store_done}, 32'd0);
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.head_valid = 1'b0; bus.head_addr_valid = 1'b0; bus.head_is_store = 1'b0;
        bus.head_addr = 32'd0; bus.head_wdata = 32'd0; bus.head_wmask = 4'd0;
        bus.head_rmask = 4'd0; bus.head_funct3 = 3'd0; bus.head_rob_idx = 5'd0;
        bus.head_pd = 6'd0; bus.rob_head_idx = 5'd0; bus.flush = 1'b0;
        bus.dmem_rdata = 32'd0; bus.dmem_resp = 1'b0;

        repeat (3) @(posedge clk);
        smp();
        check("rst_deq", {31'd0, bus.dequeue}, 32'd0);
        check("rst_rmask", {28'd0, bus.dmem_rmask}, 32'd0);
        check("rst_wmask", {28'd0, bus.dmem_wmask}, 32'd0);
        check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        check("rst_sdone", {31'd0, bus.store_done}, 32'd0);
        tick();
        rst_n = 1'b1;

        do_load("lb", 32'h0000_1003, 3'b000, 4'b1000, 32'h80AA_BBCC, 3, 32'hFFFF_FF80);
        smp();
        check("lb_pulse_end", {31'd0, bus.wb_valid}, 32'd0);
        tick();
        do_load("lhu", 32'h0000_2002, 3'b101, 4'b1100, 32'h8001_1234, 1, 32'h0000_8001);
        do_load("lw",  32'h0000_2000, 3'b010, 4'b1111, 32'h8001_1234, 2, 32'h8001_1234);
        do_load("lh",  32'h0000_2002, 3'b001, 4'b1100, 32'h8001_1234, 1, 32'hFFFF_8001);
        do_load("lbu", 32'h0000_2001, 3'b100, 4'b0010, 32'h8001_1234, 1, 32'h0000_0012);
        do_load("lh0", 32'h0000_2000, 3'b001, 4'b0011, 32'h8001_1234, 1, 32'h0000_1234);
        do_load("bad", 32'h0000_2000, 3'b011, 4'b1111, 32'h8001_1234, 1, 32'h0000_0000);

        // store gated by ROB head
        bus.head_valid = 1'b1; bus.head_addr_valid = 1'b1; bus.head_is_store = 1'b1;
        bus.head_addr = 32'h0000_5002; bus.head_funct3 = 3'b001; bus.head_wmask = 4'b1100;
        bus.head_rmask = 4'd0; bus.head_wdata = 32'hABCD_0000; bus.head_rob_idx = 5'd5;
        bus.rob_head_idx = 5'd3;
        smp();
        check("st_blocked_wmask", {28'd0, bus.dmem_wmask}, 32'd0);
        check("st_blocked_rmask", {28'd0, bus.dmem_rmask}, 32'd0);
        tick();
        bus.rob_head_idx = 5'd5;
        smp();
        check("st_wmask", {28'd0, bus.dmem_wmask}, 32'hC);
        check("st_addr", bus.dmem_addr, 32'h0000_5000);
        check("st_wdata", bus.dmem_wdata, 32'hABCD_0000);
        check("st_rmask", {28'd0, bus.dmem_rmask}, 32'd0);
        tick();
        bus.head_valid = 1'b0;
        smp();
        check("st_wait_wmask", {28'd0, bus.dmem_wmask}, 32'd0);
        tick();
        bus.dmem_resp = 1'b1;
        smp();
        check("st_deq", {31'd0, bus.dequeue}, 32'd1);
        tick();
        bus.dmem_resp = 1'b0;
        smp();
        check("st_done", {31'd0, bus.store_done}, 32'd1);
        check("st_rob", {27'd0, bus.store_rob_idx}, 32'd5);
        check("st_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        tick();
        smp();
        check("st_pulse_end", {31'd0, bus.store_done}, 32'd0);
        tick();

        // stray response in IDLE
        bus.dmem_resp = 1'b1;
        smp();
        check("idle_resp_deq", {31'd0, bus.dequeue}, 32'd0);
        tick();
        bus.dmem_resp = 1'b0;

        // flush while outstanding: drain, then next head issues after the response
        set_load(32'h0000_3000, 3'b010, 4'b1111);
        smp();
        check("dr_issue", {28'd0, bus.dmem_rmask}, 32'hF);
        tick();
        bus.head_valid = 1'b0;
        bus.flush = 1'b1;
        smp();
        check("dr_flush_deq", {31'd0, bus.dequeue}, 32'd0);
        tick();
        bus.flush = 1'b0;
        set_load(32'h0000_3004, 3'b010, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            smp();
            check("dr_block", {28'd0, bus.dmem_rmask}, 32'd0);
            tick();
        end
        bus.dmem_resp = 1'b1;
        bus.dmem_rdata = 32'hDEAD_BEEF;
        smp();
        check("dr_resp_deq", {31'd0, bus.dequeue}, 32'd0);
        check("dr_resp_rmask", {28'd0, bus.dmem_rmask}, 32'd0);
        tick();
        bus.dmem_resp = 1'b0;
        smp();
        check("dr_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        check("dr_no_sdone", {31'd0, bus.store_done}, 32'd0);
        check("dr_reissue", {28'd0, bus.dmem_rmask}, 32'hF);
        check("dr_reissue_addr", bus.dmem_addr, 32'h0000_3004);
        tick();
        bus.head_valid = 1'b0;
        bus.dmem_resp = 1'b1;
        bus.dmem_rdata = 32'h1122_3344;
        smp();
        check("dr2_deq", {31'd0, bus.dequeue}, 32'd1);
        tick();
        bus.dmem_resp = 1'b0;
        smp();
        check("dr2_wb_data", bus.wb_data, 32'h1122_3344);
        tick();

        // flush and response in the same WAIT cycle
        set_load(32'h0000_4000, 3'b010, 4'b1111);
        smp();
        tick();
        bus.head_valid = 1'b0;
        bus.flush = 1'b1;
        bus.dmem_resp = 1'b1;
        smp();
        check("fr_deq", {31'd0, bus.dequeue}, 32'd0);
        tick();
        bus.flush = 1'b0;
        bus.dmem_resp = 1'b0;
        set_load(32'h0000_4008, 3'b010, 4'b1111);
        smp();
        check("fr_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        check("fr_idle_issue", {28'd0, bus.dmem_rmask}, 32'hF);
        tick();
        bus.head_valid = 1'b0;
        bus.dmem_resp = 1'b1;
        bus.dmem_rdata = 32'h0000_00AA;
        smp();
        tick();
        // flush in IDLE: registered pulse survives, no issue
        bus.dmem_resp = 1'b0;
        bus.flush = 1'b1;
        set_load(32'h0000_6000, 3'b010, 4'b1111);
        smp();
        check("fi_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        check("fi_wb_data", bus.wb_data, 32'h0000_00AA);
        check("fi_no_issue", {28'd0, bus.dmem_rmask}, 32'd0);
        tick();
        bus.flush = 1'b0;

        // reset in WAIT
        smp();
        check("rs_issue", {28'd0, bus.dmem_rmask}, 32'hF);
        tick();
        smp();
        #1;
        bus.dmem_resp = 1'b1;
        #1;
        check("rs_pre_deq", {31'd0, bus.dequeue}, 32'd1);
        bus.head_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rs_async_deq", {31'd0, bus.dequeue}, 32'd0);
        check("rs_async_rmask", {28'd0, bus.dmem_rmask}, 32'd0);
        tick();
        bus.head_valid = 1'b0;
        rst_n = 1'b1;
        smp();
        check("rs_stray_deq", {31'd0, bus.dequeue}, 32'd0);
        tick();
        bus.dmem_resp = 1'b0;
        smp();
        check("rs_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        check("rs_no_sdone", {31'd0, bus.store_done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
